// File: rtl/fetch_issue_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_issue_unit_if
// Bundles the fetch/issue unit's control, program-load and issue signals.
//   master : drives run and the load port, observes the issue outputs
//   slave  : the fetch/issue unit itself
// Signals
//   run         fetch enable
//   load_we     instruction-memory write strobe
//   load_addr   instruction-memory write address (AW bits)
//   load_data   instruction-memory write data
//   instruction registered word issued to the datapath
//   pc          word address of the next fetch
//   stall       issued word is a hazard bubble
//   done        unit is halted
// -----------------------------------------------------------------------------
interface fetch_issue_unit_if #(
  parameter int unsigned AW = 6
);
  logic          run;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic [31:0]   instruction;
  logic [AW-1:0] pc;
  logic          stall;
  logic          done;

  modport master (
    output run, load_we, load_addr, load_data,
    input  instruction, pc, stall, done
  );

  modport slave (
    input  run, load_we, load_addr, load_data,
    output instruction, pc, stall, done
  );
endinterface

// File: rtl/fetch_issue_unit.sv
// -----------------------------------------------------------------------------
// fetch_issue_unit
// Fetches 32-bit words from a small instruction memory and issues them one
// per cycle to a datapath, inserting bubbles for read-after-write hazards
// against the last two issued writers, and draining/halting on HALT_OP.
// Ports
//   clk_fi  single rising-edge clock
//   rst_n   asynchronous active-low reset (memory contents are kept)
//   bus     fetch_issue_unit_if.slave: run, load_*, instruction, pc,
//           stall, done -- all outputs come straight from flops
// -----------------------------------------------------------------------------
module fetch_issue_unit #(
  parameter int unsigned DEPTH   = 64,
  parameter logic [31:0] NOP     = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = 6'b111111,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic            clk_fi,
  input  logic            rst_n,
  fetch_issue_unit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);

  // A word is a writer when it is an R-type op with a nonzero destination.
  function automatic logic is_writer(input logic [31:0] w);
    return (w[31:26] == 6'b000000) && (w[15:11] != 5'd0);
  endfunction

  // True when a valid scoreboard entry's destination feeds a nonzero source of w.
  function automatic logic reads_entry(input logic [31:0] w,
                                       input logic        vld,
                                       input logic [4:0]  rd);
    return vld && (((w[25:21] != 5'd0) && (w[25:21] == rd)) ||
                   ((w[20:16] != 5'd0) && (w[20:16] == rd)));
  endfunction

  logic [31:0]        imem_q [DEPTH];
  state_e             state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic               stall_q, stall_d;
  logic               done_q, done_d;
  logic               drain_cnt_q, drain_cnt_d;
  logic [1:0]         sb_vld_q, sb_vld_d;
  logic [1:0][4:0]    sb_rd_q, sb_rd_d;
  logic [31:0]        fetch_w;
  logic               hazard;

  assign fetch_w = imem_q[pc_q];
  assign hazard  = reads_entry(fetch_w, sb_vld_q[0], sb_rd_q[0]) ||
                   reads_entry(fetch_w, sb_vld_q[1], sb_rd_q[1]);

  // Program load; only honoured while the fetch path is quiescent.
  always_ff @(posedge clk_fi) begin
    if (bus.load_we && ((state_q == ST_IDLE) || (state_q == ST_HALT))) begin
      imem_q[bus.load_addr] <= bus.load_data;
    end
  end

  // Next-state, next-pc and issued-word selection.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = NOP;
    stall_d     = 1'b0;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!bus.run) begin
          state_d = ST_IDLE;
        end else if (fetch_w[31:26] == HALT_OP) begin
          // HALT_OP wins over any hazard in the same word.
          state_d     = ST_DRAIN;
          drain_cnt_d = 1'b0;
        end else if (hazard) begin
          stall_d = 1'b1;
        end else begin
          instr_d = fetch_w;
          pc_d    = (pc_q == PC_LAST) ? '0 : pc_q + PC_ONE;
        end
      end
      ST_DRAIN: begin
        // Two bubble cycles in DRAIN, then HALT.
        if (drain_cnt_q) begin
          state_d     = ST_HALT;
          drain_cnt_d = 1'b0;
        end else begin
          drain_cnt_d = 1'b1;
        end
      end
      ST_HALT: begin
        if (!bus.run) begin
          state_d = ST_IDLE;
          pc_d    = '0;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
    done_d   = (state_d == ST_HALT);
    // Scoreboard shifts every cycle; bubbles load an invalid entry.
    sb_vld_d = {sb_vld_q[0], is_writer(instr_d)};
    sb_rd_d  = {sb_rd_q[0], instr_d[15:11]};
  end

  // State, pc, issue outputs and scoreboard registers.
  always_ff @(posedge clk_fi or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      instr_q     <= NOP;
      stall_q     <= 1'b0;
      done_q      <= 1'b0;
      drain_cnt_q <= 1'b0;
      sb_vld_q    <= 2'b00;
      sb_rd_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      stall_q     <= stall_d;
      done_q      <= done_d;
      drain_cnt_q <= drain_cnt_d;
      sb_vld_q    <= sb_vld_d;
      sb_rd_q     <= sb_rd_d;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.pc          = pc_q;
  assign bus.stall       = stall_q;
  assign bus.done        = done_q;

endmodule
